object_position_buffer: RTL and testbench

Double-buffered register file holding the on-screen position and visibility of every game object (player, enemy, player bullets, enemy bullet). The processor writes a back buffer at any time, then commits it; the block copies it to the front buffer only at the start of vertical sync, so the renderer never draws a half-updated frame. It sits between the processor's position outputs and the VGA renderer. It replaces the free-running update-clock latch that currently feeds the renderer.

---
 rtl/obj_pkg.sv | 20 ++
 rtl/vsync_edge_sync.sv | 29 ++
 rtl/object_position_buffer.sv | 124 ++++++++++++
 tb/tb_object_position_buffer.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/obj_pkg.sv
// Shared definitions for the object position path: slot map, buffer states
// and screen limits used by both the position buffer and the renderer.
package obj_pkg;

  localparam int OBJ_PLAYER       = 0;
  localparam int OBJ_ENEMY        = 1;
  localparam int OBJ_BULLET       = 2;
  localparam int OBJ_ENEMY_BULLET = 3;
  localparam int OBJ_BULLET2      = 4;

  localparam int SCREEN_X_MAX = 639;
  localparam int SCREEN_Y_MAX = 479;

  typedef enum logic [1:0] {
    OPEN    = 2'd0,
    PENDING = 2'd1,
    SWAP    = 2'd2
  } bufState_e;

endpackage

// File: rtl/vsync_edge_sync.sv
// Brings the VGA vsync into the master clock domain and emits a registered
// one-cycle pulse on each falling edge (start of vertical sync).
module vsync_edge_sync (
  input  logic master_clk,
  input  logic reset,
  input  logic vga_vsync_n,
  output logic frame_tick
);

  logic sync1;
  logic sync2;
  logic hist;

  // Idle level of vsync_n is high, so reset to 1 to avoid a false edge.
  always_ff @(posedge master_clk or posedge reset) begin
    if (reset) begin
      sync1      <= 1'b1;
      sync2      <= 1'b1;
      hist       <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      sync1      <= vga_vsync_n;
      sync2      <= sync1;
      hist       <= sync2;
      frame_tick <= hist & ~sync2;
    end
  end

endmodule

// File: rtl/object_position_buffer.sv
// Double-buffered object position file: the processor fills the back buffer,
// commits it, and the front buffer is refreshed only at vsync start.
module object_position_buffer
  import obj_pkg::*;
#(
  parameter int NUM_OBJ = 5,
  parameter int X_W     = 10,
  parameter int Y_W     = 9,
  parameter int X_MAX   = SCREEN_X_MAX,
  parameter int Y_MAX   = SCREEN_Y_MAX
) (
  input  logic                   master_clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [2:0]             wr_addr,
  input  logic [X_W-1:0]         wr_x,
  input  logic [Y_W-1:0]         wr_y,
  input  logic                   wr_vis,
  input  logic                   wr_commit,
  output logic                   wr_ready,
  input  logic                   vga_vsync_n,
  output logic [NUM_OBJ*X_W-1:0] pos_x,
  output logic [NUM_OBJ*Y_W-1:0] pos_y,
  output logic [NUM_OBJ-1:0]     visible,
  output logic                   frame_tick,
  output logic                   swap_done,
  output logic                   err
);

  localparam logic [3:0]     NUM_OBJ_L = 4'(NUM_OBJ);
  localparam logic [X_W-1:0] X_LIM     = X_W'(X_MAX);
  localparam logic [Y_W-1:0] Y_LIM     = Y_W'(Y_MAX);

  bufState_e        state;
  logic [X_W-1:0]   backX [NUM_OBJ];
  logic [Y_W-1:0]   backY [NUM_OBJ];
  logic [NUM_OBJ-1:0] backVis;

  logic           addrOk;
  logic           writeOk;
  logic           commitOk;
  logic           badAccess;
  logic [X_W-1:0] clampX;
  logic [Y_W-1:0] clampY;

  assign wr_ready  = (state == OPEN);
  assign addrOk    = {1'b0, wr_addr} < NUM_OBJ_L;
  assign writeOk   = wr_en && wr_ready && addrOk;
  assign commitOk  = wr_commit && wr_ready;
  assign badAccess = (wr_en && !(wr_ready && addrOk)) || (wr_commit && !wr_ready);
  assign clampX    = (wr_x > X_LIM) ? X_LIM : wr_x;
  assign clampY    = (wr_y > Y_LIM) ? Y_LIM : wr_y;

  vsync_edge_sync uVsyncSync (
    .master_clk (master_clk),
    .reset      (reset),
    .vga_vsync_n(vga_vsync_n),
    .frame_tick (frame_tick)
  );

  // A commit landing in the same cycle as frame_tick only reaches PENDING
  // afterwards, so that tick is missed and the swap waits a full frame.
  always_ff @(posedge master_clk or posedge reset) begin
    if (reset) begin
      state     <= OPEN;
      swap_done <= 1'b0;
      err       <= 1'b0;
    end else begin
      if (badAccess) err <= 1'b1;
      case (state)
        OPEN: begin
          swap_done <= 1'b0;
          if (commitOk) state <= PENDING;
        end
        PENDING: begin
          if (frame_tick) begin
            state     <= SWAP;
            swap_done <= 1'b1;
          end
        end
        SWAP: begin
          state     <= OPEN;
          swap_done <= 1'b0;
        end
        default: begin
          state     <= OPEN;
          swap_done <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: these buffers are small flop arrays rather than RAM, so they can and
  // do take the asynchronous reset; a RAM macro would have to be cleared by writes.
  always_ff @(posedge master_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_OBJ; i++) begin
        backX[i] <= '0;
        backY[i] <= '0;
      end
      backVis <= '0;
    end else if (writeOk) begin
      backX[wr_addr]   <= clampX;
      backY[wr_addr]   <= clampY;
      backVis[wr_addr] <= wr_vis;
    end
  end

  // Back buffer is copied, not moved, so later updates only touch changed slots.
  always_ff @(posedge master_clk or posedge reset) begin
    if (reset) begin
      pos_x   <= '0;
      pos_y   <= '0;
      visible <= '0;
    end else if (state == SWAP) begin
      for (int i = 0; i < NUM_OBJ; i++) begin
        pos_x[i*X_W +: X_W] <= backX[i];
        pos_y[i*Y_W +: Y_W] <= backY[i];
      end
      visible <= backVis;
    end
  end

endmodule

// File: tb/tb_object_position_buffer.sv
// Self-checking bench for object_position_buffer: edge-counted behavioural
// model compared every cycle, plus directed literal checks.
module tb_object_position_buffer;

  localparam int N = 5;

  logic          master_clk;
  logic          reset;
  logic          wr_en;
  logic [2:0]    wr_addr;
  logic [9:0]    wr_x;
  logic [8:0]    wr_y;
  logic          wr_vis;
  logic          wr_commit;
  logic          wr_ready;
  logic          vga_vsync_n;
  logic [49:0]   pos_x;
  logic [44:0]   pos_y;
  logic [4:0]    visible;
  logic          frame_tick;
  logic          swap_done;
  logic          err;

  int tests = 0;
  int fails = 0;
  int tickCount = 0;
  int swapCount = 0;

  object_position_buffer dut (
    .master_clk (master_clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_x       (wr_x),
    .wr_y       (wr_y),
    .wr_vis     (wr_vis),
    .wr_commit  (wr_commit),
    .wr_ready   (wr_ready),
    .vga_vsync_n(vga_vsync_n),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .visible    (visible),
    .frame_tick (frame_tick),
    .swap_done  (swap_done),
    .err        (err)
  );

  initial master_clk = 1'b0;
  always #10 master_clk = ~master_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (edge-counted timeline) ----------------
  logic [9:0] mBackX [N];
  logic [8:0] mBackY [N];
  logic       mBackV [N];
  logic [9:0] mFrontX [N];
  logic [8:0] mFrontY [N];
  logic       mFrontV [N];
  logic       mLocked;     // commit outstanding: from accepted commit to front update
  int         mEdge;
  int         mSwapEdge;   // edge number at which the front buffer takes the back buffer
  logic [3:0] mSamp;       // [k] = vsync_n sampled k edges ago
  logic       mTick;
  logic       mSwapDone;
  logic       mErr;
  logic       lockedPre;
  logic       tickPre;

  always @(posedge master_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        mBackX[i] = '0; mBackY[i] = '0; mBackV[i] = 1'b0;
        mFrontX[i] = '0; mFrontY[i] = '0; mFrontV[i] = 1'b0;
      end
      mLocked = 1'b0; mEdge = 0; mSwapEdge = -1; mSamp = 4'hF;
      mTick = 1'b0; mSwapDone = 1'b0; mErr = 1'b0;
    end else begin
      mEdge++;
      lockedPre = mLocked;
      tickPre   = mTick;
      mSwapDone = 1'b0;
      if (mSwapEdge == mEdge) begin
        for (int i = 0; i < N; i++) begin
          mFrontX[i] = mBackX[i]; mFrontY[i] = mBackY[i]; mFrontV[i] = mBackV[i];
        end
        mLocked   = 1'b0;
        mSwapEdge = -1;
      end else if (lockedPre && tickPre && mSwapEdge < 0) begin
        mSwapEdge = mEdge + 1;
        mSwapDone = 1'b1;
      end
      if (wr_en && (lockedPre || int'(wr_addr) >= N)) mErr = 1'b1;
      if (wr_commit && lockedPre) mErr = 1'b1;
      if (wr_en && !lockedPre && int'(wr_addr) < N) begin
        mBackX[wr_addr] = (wr_x > 10'd639) ? 10'd639 : wr_x;
        mBackY[wr_addr] = (wr_y > 9'd479) ? 9'd479 : wr_y;
        mBackV[wr_addr] = wr_vis;
      end
      if (wr_commit && !lockedPre) mLocked = 1'b1;
      mSamp = {mSamp[2:0], vga_vsync_n};
      mTick = !mSamp[2] && mSamp[3];
    end
  end

  function automatic logic [49:0] expPosX();
    logic [49:0] r;
    for (int i = 0; i < N; i++) r[i*10 +: 10] = mFrontX[i];
    return r;
  endfunction

  function automatic logic [44:0] expPosY();
    logic [44:0] r;
    for (int i = 0; i < N; i++) r[i*9 +: 9] = mFrontY[i];
    return r;
  endfunction

  function automatic logic [4:0] expVis();
    logic [4:0] r;
    for (int i = 0; i < N; i++) r[i] = mFrontV[i];
    return r;
  endfunction

  always @(negedge master_clk) begin
    if (!reset) begin
      check("cyc_pos_x", 64'(pos_x), 64'(expPosX()));
      check("cyc_pos_y", 64'(pos_y), 64'(expPosY()));
      check("cyc_visible", 64'(visible), 64'(expVis()));
      check("cyc_wr_ready", 64'(wr_ready), 64'(!mLocked));
      check("cyc_frame_tick", 64'(frame_tick), 64'(mTick));
      check("cyc_swap_done", 64'(swap_done), 64'(mSwapDone));
      check("cyc_err", 64'(err), 64'(mErr));
      if (frame_tick) tickCount++;
      if (swap_done) swapCount++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) @(posedge master_clk);
    #1;
  endtask

  task automatic do_write(input logic [2:0] a, input logic [9:0] x, input logic [8:0] y, input logic v);
    wr_en = 1'b1; wr_addr = a; wr_x = x; wr_y = y; wr_vis = v;
    step(1);
    wr_en = 1'b0;
  endtask

  task automatic do_commit();
    wr_commit = 1'b1;
    step(1);
    wr_commit = 1'b0;
  endtask

  task automatic do_vsync();
    vga_vsync_n = 1'b0;
    step(4);
    vga_vsync_n = 1'b1;
    step(6);
  endtask

  function automatic logic [9:0] slotX(input int i);
    return pos_x[i*10 +: 10];
  endfunction

  function automatic logic [8:0] slotY(input int i);
    return pos_y[i*9 +: 9];
  endfunction

  int t0;
  int s0;

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_x = '0; wr_y = '0;
    wr_vis = 1'b0; wr_commit = 1'b0; vga_vsync_n = 1'b1;
    step(3);
    reset = 1'b0;
    step(2);
    check("rst_pos_x", 64'(pos_x), 64'd0);
    check("rst_pos_y", 64'(pos_y), 64'd0);
    check("rst_visible", 64'(visible), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_wr_ready", 64'(wr_ready), 64'd1);

    // Idle for two frames
    t0 = tickCount; s0 = swapCount;
    do_vsync();
    do_vsync();
    check("idle_ticks", 64'(tickCount - t0), 64'd2);
    check("idle_swaps", 64'(swapCount - s0), 64'd0);

    // Slot 0 write, commit, exact swap timing
    s0 = swapCount;
    do_write(3'd0, 10'd315, 9'd440, 1'b1);
    do_commit();
    step(3);
    check("pend_hold_x0", 64'(slotX(0)), 64'd0);
    check("pend_wr_ready", 64'(wr_ready), 64'd0);
    vga_vsync_n = 1'b0;
    step(1);                                   // after edge t
    step(2);                                   // after edge t+2
    check("t2_frame_tick", 64'(frame_tick), 64'd1);
    step(1);                                   // after edge t+3
    check("t3_swap_done", 64'(swap_done), 64'd1);
    check("t3_x0_old", 64'(slotX(0)), 64'd0);
    check("t3_wr_ready", 64'(wr_ready), 64'd0);
    step(1);                                   // after edge t+4
    check("t4_x0", 64'(slotX(0)), 64'd315);
    check("t4_y0", 64'(slotY(0)), 64'd440);
    check("t4_vis0", 64'(visible[0]), 64'd1);
    check("t4_wr_ready", 64'(wr_ready), 64'd1);
    check("t4_swap_done", 64'(swap_done), 64'd0);
    step(1);
    vga_vsync_n = 1'b1;
    step(6);
    check("slot0_swaps", 64'(swapCount - s0), 64'd1);

    // Clamp to screen limits
    do_write(3'd2, 10'd700, 9'd500, 1'b1);
    do_commit();
    do_vsync();
    check("clamp_x2", 64'(slotX(2)), 64'd639);
    check("clamp_y2", 64'(slotY(2)), 64'd479);

    // Commit coincident with vsync start: swap deferred one frame
    do_write(3'd3, 10'd639, 9'd0, 1'b1);
    s0 = swapCount;
    vga_vsync_n = 1'b0;
    step(3);                                   // frame_tick high now
    check("coinc_tick", 64'(frame_tick), 64'd1);
    wr_commit = 1'b1;
    step(1);
    wr_commit = 1'b0;
    step(1);
    vga_vsync_n = 1'b1;
    step(6);
    check("coinc_no_swap", 64'(swapCount - s0), 64'd0);
    check("coinc_x3_old", 64'(slotX(3)), 64'd0);
    check("coinc_pending", 64'(wr_ready), 64'd0);
    do_vsync();
    check("coinc_swaps", 64'(swapCount - s0), 64'd1);
    check("coinc_x3_new", 64'(slotX(3)), 64'd639);
    check("coinc_vis3", 64'(visible[3]), 64'd1);

    // Out-of-range address in OPEN
    check("pre_err", 64'(err), 64'd0);
    do_write(3'd6, 10'd1, 9'd2, 1'b1);
    step(1);
    check("addr6_err", 64'(err), 64'd1);
    do_commit();
    do_vsync();
    check("addr6_x0_kept", 64'(slotX(0)), 64'd315);
    check("addr6_x4_kept", 64'(slotX(4)), 64'd0);

    // Write and commit while PENDING are dropped
    do_write(3'd1, 10'd100, 9'd200, 1'b1);
    do_commit();
    do_write(3'd1, 10'd50, 9'd60, 1'b0);
    do_commit();
    do_vsync();
    check("pend_x1", 64'(slotX(1)), 64'd100);
    check("pend_y1", 64'(slotY(1)), 64'd200);
    check("pend_vis1", 64'(visible[1]), 64'd1);
    check("pend_err", 64'(err), 64'd1);

    // Reset during PENDING
    do_write(3'd4, 10'd123, 9'd45, 1'b1);
    do_commit();
    step(2);
    reset = 1'b1;
    step(1);
    check("mid_rst_pos_x", 64'(pos_x), 64'd0);
    check("mid_rst_pos_y", 64'(pos_y), 64'd0);
    check("mid_rst_visible", 64'(visible), 64'd0);
    check("mid_rst_err", 64'(err), 64'd0);
    check("mid_rst_ready", 64'(wr_ready), 64'd1);
    reset = 1'b0;
    step(2);
    s0 = swapCount;
    do_vsync();
    check("post_rst_swaps", 64'(swapCount - s0), 64'd0);
    check("post_rst_x4", 64'(slotX(4)), 64'd0);
    check("post_rst_ready", 64'(wr_ready), 64'd1);

    step(4);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
